// File: rtl/cnn_window_gen.sv
// Raster-stream KxK sliding-window generator feeding the convolution engine.
// Optional define CNN_WINGEN_SOF_ERR_EN adds a sof_err pulse for sof arriving mid-frame.
module cnn_window_gen #(
   parameter int KERNEL = 3,
   parameter int N      = 4,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N-1:0]               pix_in,
   input  logic                       pix_valid,
   input  logic                       sof,
   output logic [KERNEL*KERNEL*N-1:0] data2conv,
   output logic                       en_out,
   output logic                       frame_done
`ifdef CNN_WINGEN_SOF_ERR_EN
   ,
   output logic                       sof_err
`endif
);

   localparam int WW = KERNEL * KERNEL * N;
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int LB = (KERNEL > 1) ? KERNEL - 1 : 1;

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   state_t         state;
   logic [CW-1:0]  col, ec;
   logic [RW-1:0]  row, er;
   logic [WW-1:0]  win, win_next;
   logic [N-1:0]   line_buf [LB][IMG_W];
   logic           emit, last_pix;

   // sof relocates the accepted pixel to (0,0) before any position-based decision
   assign ec       = sof ? '0 : col;
   assign er       = sof ? '0 : row;
   assign last_pix = (ec == CW'(IMG_W - 1)) && (er == RW'(IMG_H - 1));
   assign emit     = pix_valid && (int'(er) >= KERNEL - 1) && (int'(ec) >= KERNEL - 1);

   always_comb begin
      win_next = win;
      for (int unsigned r = 0; r < KERNEL; r++) begin
         for (int unsigned c = 0; c + 1 < KERNEL; c++) begin
            win_next[(r*KERNEL+c)*N +: N] = win[(r*KERNEL+c+1)*N +: N];
         end
      end
      for (int unsigned r = 0; r + 1 < KERNEL; r++) begin
         win_next[(r*KERNEL+KERNEL-1)*N +: N] = line_buf[KERNEL-2-r][ec];
      end
      win_next[((KERNEL-1)*KERNEL+KERNEL-1)*N +: N] = pix_in;
   end

   generate
      if (KERNEL > 1) begin : g_lb
         always_ff @(posedge clk) begin
            if (pix_valid) begin
               line_buf[0][ec] <= pix_in;
               for (int unsigned i = 1; i + 1 < KERNEL; i++) begin
                  line_buf[i][ec] <= line_buf[i-1][ec];
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col   <= '0;
         row   <= '0;
         state <= IDLE;
      end else if (pix_valid) begin
         if (ec == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= (er == RW'(IMG_H - 1)) ? '0 : er + 1'b1;
         end else begin
            col <= ec + 1'b1;
            row <= er;
         end
         if (sof || state == IDLE)
            state <= (KERNEL == 1) ? RUN : FILL;
         else if (state == FILL && int'(er) == KERNEL - 1)
            state <= RUN;
         else if (state == RUN && last_pix && KERNEL > 1)
            state <= FILL;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win        <= '0;
         data2conv  <= '0;
         en_out     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         en_out     <= emit;
         frame_done <= emit && last_pix;
         if (pix_valid) win <= win_next;
         if (emit) data2conv <= win_next;
      end
   end

`ifdef CNN_WINGEN_SOF_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sof_err <= 1'b0;
      else     sof_err <= pix_valid && sof && (col != '0 || row != '0) && state != IDLE;
   end
`endif

endmodule
